// File: rtl/adc_conv_seq.sv
// Conversion sequencer for the pipelined ADC correction datapath: two-phase advance
// strobes, burst launch, datapath clear, corrected-word valid tracking and completion.
module adc_conv_seq #(
   parameter int HALF_W   = 4,
   parameter int CNT_W    = 16,
   parameter int PIPE_LAT = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic [HALF_W-1:0] half_cfg,
   output logic              p1_en,
   output logic              p2_en,
   output logic              sample_stb,
   output logic              dp_clr,
   output logic              out_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sample_cnt
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [HALF_W:0]   PH_ONE   = {{HALF_W{1'b0}}, 1'b1};
   localparam logic [HALF_W-1:0] HALF_ONE = {{(HALF_W-1){1'b0}}, 1'b1};

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     len_reg, launched_reg, cnt_reg;
   logic [HALF_W-1:0]    half_reg;
   logic [HALF_W:0]      ph_reg, ph_last;
   logic [PIPE_LAT-1:0]  trk_reg, trk_next;
   logic                 ov_reg;
   logic                 accept, active, phase_on, p1_raw, p2_raw, last_launch, last_out;

   assign accept      = start && !abort && (burst_len != '0);
   assign active      = (state_reg != IDLE);
   assign phase_on    = (state_reg == RUN) || (state_reg == DRAIN);
   assign ph_last     = {half_reg, 1'b0} - PH_ONE;
   assign p1_raw      = phase_on && (ph_reg == '0);
   assign p2_raw      = phase_on && (ph_reg == {1'b0, half_reg});
   assign last_launch = (launched_reg + CNT_ONE) == len_reg;
   assign last_out    = (cnt_reg + CNT_ONE) == len_reg;
   assign sample_cnt  = cnt_reg;

   // Tracker shifts one slot per p1 event; the oldest slot marks a word leaving the pipe.
   assign trk_next[0] = sample_stb;
   generate
      for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_trk
         assign trk_next[gi] = trk_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (abort && active) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (accept) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN:     if (sample_stb && last_launch) state_next = DRAIN;
            DRAIN:   if (done) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Abort masks every strobe in its own cycle and turns it into a datapath clear.
   always_comb begin
      p1_en      = 1'b0;
      p2_en      = 1'b0;
      sample_stb = 1'b0;
      dp_clr     = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      busy       = active;
      if (abort && active) begin
         dp_clr = 1'b1;
      end else begin
         dp_clr     = (state_reg == CLEAR);
         p1_en      = p1_raw;
         p2_en      = p2_raw;
         sample_stb = (state_reg == RUN) && p1_raw && (launched_reg < len_reg);
         out_valid  = ov_reg;
         done       = (state_reg == DRAIN) && ov_reg && last_out;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_reg      <= '0;
         half_reg     <= '0;
         launched_reg <= '0;
         cnt_reg      <= '0;
         ph_reg       <= '0;
         trk_reg      <= '0;
         ov_reg       <= 1'b0;
      end else if (state_reg == IDLE && accept) begin
         len_reg      <= burst_len;
         half_reg     <= (half_cfg == '0) ? HALF_ONE : half_cfg;
         launched_reg <= '0;
         cnt_reg      <= '0;
         ph_reg       <= '0;
         trk_reg      <= '0;
         ov_reg       <= 1'b0;
      end else if (abort && active) begin
         ph_reg  <= '0;
         trk_reg <= '0;
         ov_reg  <= 1'b0;
      end else begin
         if (phase_on && (state_next == RUN || state_next == DRAIN))
            ph_reg <= (ph_reg == ph_last) ? '0 : ph_reg + PH_ONE;
         else
            ph_reg <= '0;
         if (sample_stb) launched_reg <= launched_reg + CNT_ONE;
         if (p1_en)      trk_reg <= trk_next;
         ov_reg <= p1_en && trk_reg[PIPE_LAT-1];
         if (out_valid)  cnt_reg <= cnt_reg + CNT_ONE;
      end
   end

endmodule

// File: doc/adc_conv_seq.md
Name: adc_conv_seq

Overview:
Single-clock conversion sequencer for the pipelined ADC digital-correction datapath (comparator encoders, per-stage delay lines and the 13-bit overlap-add output register).
- Generates the two phase enables (p1_en, p2_en) that advance the stage delay lines.
- Launches a programmed burst of samples and clears the datapath before each burst.
- Flags the output cycles that carry a fully corrected 13-bit word.
- Signals completion, and supports abort.

Parameters:
HALF_W, 4, width of the half-period configuration
CNT_W, 16, width of burst length and sample counters
PIPE_LAT, 6, number of p1 events from sample launch to corrected word present at the output-register input (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  begin burst (level sampled each clk)
abort  in  1  terminate burst immediately
burst_len  in  CNT_W  number of samples per burst, latched at start
half_cfg  in  HALF_W  clk cycles per phase half-period, latched at start
p1_en  out  1  phase-1 advance strobe for stage delay lines
p2_en  out  1  phase-2 advance strobe for stage delay lines
sample_stb  out  1  comparator front-end sample strobe
dp_clr  out  1  synchronous clear to datapath registers
out_valid  out  1  corrected output word valid (1-cycle pulse)
busy  out  1  burst in progress
done  out  1  burst complete (1-cycle pulse)
sample_cnt  out  CNT_W  out_valid pulses in current/last burst

Behaviour:
- Reset (rst=0, async) clears all outputs and state to 0; FSM goes to IDLE.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - busy=0; phase counter held at 0; no strobes.
  - start=1 with burst_len!=0 and abort=0: latch burst_len and half_cfg (0 is treated as 1), clear sample_cnt and the valid tracker, go to CLEAR.
  - start with burst_len==0 is ignored.
- CLEAR: exactly 1 cycle; dp_clr=1, busy=1; goes to RUN.
- Phase generator (RUN and DRAIN only), with H = latched half_cfg:
  - p1_en is high in the first RUN cycle, then every 2H cycles.
  - p2_en is high exactly H cycles after each p1_en.
  - p1_en and p2_en are never high in the same cycle. With H=1 they alternate every cycle.
- RUN:
  - sample_stb = p1_en while launched < burst_len; each strobe increments launched.
  - On the p1_en that launches sample burst_len, go to DRAIN.
- Valid tracker:
  - PIPE_LAT-bit shift register advanced only on p1_en; input is sample_stb.
  - out_valid is high in the cycle after the p1_en that occurs PIPE_LAT p1 events after the launching p1_en. This aligns with the registered calc_out.
  - sample_cnt increments on each out_valid.
- DRAIN:
  - Phase generator keeps running; sample_stb=0.
  - In the cycle of the last out_valid (sample_cnt reaching burst_len): done=1, then go to IDLE. busy=0 from the next cycle.
- abort (RUN, CLEAR or DRAIN):
  - Has priority over every other event in the same cycle.
  - Forces p1_en, p2_en, sample_stb, out_valid and done to 0 that cycle, and sets dp_clr=1 that cycle.
  - Clears the tracker and goes to IDLE; busy=0 next cycle.
  - sample_cnt holds its value.
- start while busy is ignored. abort in IDLE has no effect. In IDLE, simultaneous start and abort: abort wins, no burst starts.
- Phase counter and launched counter are cleared on entry to CLEAR. No wrap occurs within a burst.
- sample_cnt holds its value after done until the next accepted start.

Test Plan:
1. Burst 3, H=2, PIPE_LAT=6, start at cycle 0 -> dp_clr at 1; p1_en at 2,6,10,14…; p2_en at 4,8,…; sample_stb at 2,6,10; out_valid at 27,31,35; done at 35; busy 1..35; sample_cnt=3.
2. H=1, burst 1 -> p1_en/p2_en alternate each cycle from cycle 2; out_valid at 15; done at 15; never p1_en&p2_en.
3. half_cfg=0, burst 2 -> identical timing to H=1.
4. Abort at cycle 20 of test 1 -> all strobes 0 at 20; dp_clr=1 at 20; no out_valid/done thereafter; busy=0 at 21; sample_cnt=0.
5. start with burst_len=0 -> stays IDLE, busy=0. Second start at cycle 12 during test-1 burst -> ignored, timing unchanged.
6. rst asserted mid-DRAIN -> all outputs 0 immediately (async); after release, start restarts cleanly with test-1 timing.
